// File: rtl/mac_tree_stream.sv
// mac_tree_stream: streaming multiply-add tree, dot-product accumulator, requantiser.
// Define MAC_TREE_ROUND_EN for round-half-up; default build truncates.
module mac_tree_stream #(
  parameter int MAC_NUM       = 4,
  parameter int ACCU_NUM_LOG2 = 2,
  parameter int BW_ACT        = 8,
  parameter int BW_WET        = 8,
  parameter int BW_ACCU       = 32,
  parameter int BW_OUT        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic PE_in_valid,
  output logic PE_in_ready,
  input  logic PE_in_last,
  input  logic [(MAC_NUM<<ACCU_NUM_LOG2)*BW_ACT-1:0] PE_act_in,
  input  logic [(BW_WET<<ACCU_NUM_LOG2)-1:0] PE_wet_in,
  input  logic [7:0] PE_res_shift_num,
  input  logic PE_relu_en,
  output logic PE_out_valid,
  input  logic PE_out_ready,
  output logic [MAC_NUM*BW_OUT-1:0] PE_result_out,
  output logic [MAC_NUM-1:0] PE_sat_out
);

  localparam int ACCU_NUM = 1 << ACCU_NUM_LOG2;
  localparam int NODES = 2 * ACCU_NUM - 1;
  localparam int LVL = ACCU_NUM_LOG2;
  localparam int PW = BW_ACT + BW_WET;
  localparam logic [7:0] SHIFT_LIM = 8'(BW_ACCU);
  localparam logic signed [BW_ACCU:0] QMAX =
    (BW_ACCU+1)'((1 << (BW_OUT-1)) - 1);
  localparam logic signed [BW_ACCU:0] QMIN = ~QMAX;

  logic stall;

  logic signed [BW_ACCU-1:0] leaf [MAC_NUM][ACCU_NUM];
  // heap layout: node 0 is the root, leaves sit at ACCU_NUM-1 and up
  logic signed [BW_ACCU-1:0] node [MAC_NUM][NODES];

  logic       st_v     [LVL+1];
  logic       st_last  [LVL+1];
  logic [7:0] st_shift [LVL+1];
  logic       st_relu  [LVL+1];

  logic signed [BW_ACCU-1:0] acc     [MAC_NUM];
  logic signed [BW_ACCU-1:0] fin_sum [MAC_NUM];
  logic       fin_v;
  logic [7:0] fin_shift;
  logic       fin_relu;

  logic [BW_OUT-1:0]  q_res [MAC_NUM];
  logic [MAC_NUM-1:0] q_sat;

  assign stall = PE_out_valid & ~PE_out_ready;
  assign PE_in_ready = ~stall;

  always_comb begin
    for (int r = 0; r < MAC_NUM; r++) begin
      for (int k = 0; k < ACCU_NUM; k++) begin
        leaf[r][k] = BW_ACCU'(
          PW'($signed(PE_act_in[(r*ACCU_NUM+k)*BW_ACT +: BW_ACT])) *
          PW'($signed(PE_wet_in[k*BW_WET +: BW_WET])));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < MAC_NUM; r++) begin
        for (int n = 0; n < NODES; n++) begin
          node[r][n] <= '0;
        end
      end
    end else if (!stall) begin
      for (int r = 0; r < MAC_NUM; r++) begin
        for (int n = 0; n < ACCU_NUM - 1; n++) begin
          node[r][n] <= node[r][2*n+1] + node[r][2*n+2];
        end
        for (int k = 0; k < ACCU_NUM; k++) begin
          node[r][ACCU_NUM-1+k] <= leaf[r][k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s <= LVL; s++) begin
        st_v[s]     <= 1'b0;
        st_last[s]  <= 1'b0;
        st_shift[s] <= '0;
        st_relu[s]  <= 1'b0;
      end
    end else if (!stall) begin
      st_v[0]     <= PE_in_valid;
      st_last[0]  <= PE_in_last;
      st_shift[0] <= PE_res_shift_num;
      st_relu[0]  <= PE_relu_en;
      for (int s = 1; s <= LVL; s++) begin
        st_v[s]     <= st_v[s-1];
        st_last[s]  <= st_last[s-1];
        st_shift[s] <= st_shift[s-1];
        st_relu[s]  <= st_relu[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fin_v     <= 1'b0;
      fin_shift <= '0;
      fin_relu  <= 1'b0;
      for (int r = 0; r < MAC_NUM; r++) begin
        acc[r]     <= '0;
        fin_sum[r] <= '0;
      end
    end else if (!stall) begin
      fin_v     <= st_v[LVL] & st_last[LVL];
      fin_shift <= st_shift[LVL];
      fin_relu  <= st_relu[LVL];
      for (int r = 0; r < MAC_NUM; r++) begin
        if (st_v[LVL]) begin
          if (st_last[LVL]) begin
            fin_sum[r] <= acc[r] + node[r][0];
            acc[r]     <= '0;
          end else begin
            acc[r] <= acc[r] + node[r][0];
          end
        end
      end
    end
  end

`ifdef MAC_TREE_ROUND_EN
  localparam logic signed [BW_ACCU:0] ONE = 1;
`endif

  always_comb begin
    logic signed [BW_ACCU:0] ext;
    logic signed [BW_ACCU:0] q;
    q_sat = '0;
    for (int r = 0; r < MAC_NUM; r++) begin
      ext = {fin_sum[r][BW_ACCU-1], fin_sum[r]};
`ifdef MAC_TREE_ROUND_EN
      // one extra bit so the rounding add cannot wrap
      if (fin_shift != 8'd0) begin
        ext = ext + (ONE << (fin_shift - 8'd1));
      end
`endif
      if (fin_shift >= SHIFT_LIM) begin
        q = {(BW_ACCU+1){fin_sum[r][BW_ACCU-1]}};
      end else begin
        q = ext >>> fin_shift;
      end
      if (fin_relu && q[BW_ACCU]) begin
        q = '0;
      end
      q_res[r] = q[BW_OUT-1:0];
      if (q > QMAX) begin
        q_res[r] = QMAX[BW_OUT-1:0];
        q_sat[r] = 1'b1;
      end else if (q < QMIN) begin
        q_res[r] = QMIN[BW_OUT-1:0];
        q_sat[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PE_out_valid  <= 1'b0;
      PE_result_out <= '0;
      PE_sat_out    <= '0;
    end else if (!stall) begin
      PE_out_valid <= fin_v;
      if (fin_v) begin
        for (int r = 0; r < MAC_NUM; r++) begin
          PE_result_out[r*BW_OUT +: BW_OUT] <= q_res[r];
        end
        PE_sat_out <= q_sat;
      end
    end
  end

endmodule

// File: tb/tb_mac_tree_stream.sv
// tb_mac_tree_stream: randomized scoreboard bench for mac_tree_stream.
// Reference model works on whole dot products with plain integer arithmetic.
module tb_mac_tree_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        PE_in_valid;
  logic        PE_in_ready;
  logic        PE_in_last;
  logic [31:0] PE_act_in;
  logic [15:0] PE_wet_in;
  logic [7:0]  PE_res_shift_num;
  logic        PE_relu_en;
  logic        PE_out_valid;
  logic        PE_out_ready;
  logic [15:0] PE_result_out;
  logic [1:0]  PE_sat_out;

  always #5 clk = ~clk;

  mac_tree_stream #(
    .MAC_NUM(2), .ACCU_NUM_LOG2(1), .BW_ACT(8),
    .BW_WET(8), .BW_ACCU(32), .BW_OUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PE_in_valid(PE_in_valid),
    .PE_in_ready(PE_in_ready),
    .PE_in_last(PE_in_last),
    .PE_act_in(PE_act_in),
    .PE_wet_in(PE_wet_in),
    .PE_res_shift_num(PE_res_shift_num),
    .PE_relu_en(PE_relu_en),
    .PE_out_valid(PE_out_valid),
    .PE_out_ready(PE_out_ready),
    .PE_result_out(PE_result_out),
    .PE_sat_out(PE_sat_out)
  );

  typedef struct {
    logic [15:0] res;
    logic [1:0]  sat;
  } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  int     checks = 0;
  int     failures = 0;
  longint msum0, msum1;
  bit     done;
  int     lat;

  task automatic chk(input string nm, input logic signed [63:0] a,
                     input logic signed [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, a, e);
    end
  endtask

  function automatic void quant(input longint s, input int sh,
                                input bit relu, output logic [7:0] q,
                                output logic sat);
    longint t;
    s = longint'(int'(s));
    if (sh >= 32) begin
      t = (s < 0) ? -1 : 0;
    end else begin
      t = s;
`ifdef MAC_TREE_ROUND_EN
      if (sh > 0) t = t + (longint'(1) << (sh - 1));
`endif
      t = t >>> sh;
    end
    if (relu && t < 0) t = 0;
    sat = 1'b0;
    if (t > 127) begin
      t = 127;
      sat = 1'b1;
    end else if (t < -128) begin
      t = -128;
      sat = 1'b1;
    end
    q = t[7:0];
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic send_beat(input int a00, input int a01, input int a10,
                           input int a11, input int w0, input int w1,
                           input bit last, input int sh, input bit relu);
    exp_t e;
    logic [7:0] q0, q1;
    logic s0, s1;
    bit ok;
    int n;
    PE_act_in = {a11[7:0], a10[7:0], a01[7:0], a00[7:0]};
    PE_wet_in = {w1[7:0], w0[7:0]};
    PE_in_last = last;
    PE_res_shift_num = sh[7:0];
    PE_relu_en = relu;
    PE_in_valid = 1'b1;
    msum0 += longint'(a00 * w0 + a01 * w1);
    msum1 += longint'(a10 * w0 + a11 * w1);
    if (last) begin
      quant(msum0, sh, relu, q0, s0);
      quant(msum1, sh, relu, q1, s1);
      e.res = {q1, q0};
      e.sat = {s1, s0};
      sbq.push_back(e);
      msum0 = 0;
      msum1 = 0;
    end
    ok = 1'b0;
    n = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = PE_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("in_accept", ok, 1);
    PE_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sbq.size() == 0 && !PE_out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_queue", sbq.size(), 0);
    chk("drain_valid", PE_out_valid, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && PE_out_valid && PE_out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", PE_out_valid, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("result", PE_result_out, mon_e.res);
          chk("sat", PE_sat_out, mon_e.sat);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    PE_in_valid = 1'b0;
    PE_in_last = 1'b0;
    PE_act_in = '0;
    PE_wet_in = '0;
    PE_res_shift_num = '0;
    PE_relu_en = 1'b0;
    PE_out_ready = 1'b1;
    msum0 = 0;
    msum1 = 0;
    done = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", PE_out_valid, 0);
    chk("rst_result", PE_result_out, 0);
    chk("rst_sat", PE_sat_out, 0);
    chk("rst_in_ready", PE_in_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    send_beat(3, 4, 3, 4, 5, 6, 1'b1, 0, 1'b0);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (PE_out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 3);
    wait_drain();

    for (int b = 0; b < 3; b++) send_beat(10, 10, 10, 10, 10, 10, b == 2, 2, 1'b0);
    for (int b = 0; b < 3; b++) send_beat(10, 10, 10, 10, -10, -10, b == 2, 2, 1'b0);
    send_beat(1, 1, 1, 1, 3, 3, 1'b1, 2, 1'b0);
    send_beat(1, 1, 1, 1, -3, -3, 1'b1, 2, 1'b0);
    send_beat(5, 5, 5, 5, -5, -5, 1'b1, 0, 1'b1);
    send_beat(5, 5, 5, 5, -5, -5, 1'b1, 40, 1'b0);
    send_beat(5, 5, 5, 5, -5, -5, 1'b1, 32, 1'b0);
    send_beat(5, 5, 5, 5, -5, -5, 1'b1, 31, 1'b0);
    send_beat(7, 9, 7, 9, 5, 5, 1'b1, 255, 1'b0);
    wait_drain();

    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_beat(16 * i, 0, rnd8(), rnd8(), 1, rnd8(), 1'b1, 0, 1'b0);
        end
      end
      begin
        int n;
        logic [15:0] snap;
        logic [1:0] ssat;
        n = 0;
        while (!PE_out_valid && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("bp_first_valid", PE_out_valid, 1);
        PE_out_ready = 1'b0;
        @(negedge clk);
        snap = PE_result_out;
        ssat = PE_sat_out;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_in_ready", PE_in_ready, 0);
          chk("bp_hold_valid", PE_out_valid, 1);
          chk("bp_hold_res", PE_result_out, snap);
          chk("bp_hold_sat", PE_sat_out, ssat);
        end
        @(posedge clk);
        #1;
        PE_out_ready = 1'b1;
      end
    join
    wait_drain();

    send_beat(rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), 1'b0, 0, 1'b0);
    send_beat(rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), 1'b0, 0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", PE_out_valid, 0);
    chk("mid_rst_ready", PE_in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    msum0 = 0;
    msum1 = 0;
    send_beat(1, 1, 1, 1, 2, 2, 1'b1, 0, 1'b0);
    wait_drain();

    fork
      begin
        for (int d = 0; d < 40; d++) begin
          int nb;
          int sh;
          bit rl;
          nb = $urandom_range(1, 4);
          sh = ($urandom_range(0, 7) == 0) ? $urandom_range(28, 60)
                                            : $urandom_range(0, 12);
          rl = bit'($urandom_range(0, 1));
          for (int b = 0; b < nb; b++) begin
            if (b == nb - 1) begin
              send_beat(rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), rnd8(),
                        1'b1, sh, rl);
            end else begin
              send_beat(rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), rnd8(),
                        1'b0, $urandom_range(0, 63),
                        bit'($urandom_range(0, 1)));
            end
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          PE_out_ready = ($urandom_range(0, 3) != 0);
        end
        PE_out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
